// File: rtl/multiphase_reference_sequencer.sv
// Multiphase dq->phase current reference sequencer: DDS angle emulation, Id/Iq scaling into a
// double-buffered bank, framed AXI-Stream output. Optional clamping via MPRS_SATURATION_EN.
module multiphase_reference_sequencer #(
  parameter int N_PHASES        = 6,
  parameter int DATA_PATH_WIDTH = 16,
  parameter int PHASE_WIDTH     = 16,
  localparam int DW             = $clog2(N_PHASES),
  localparam int W              = DATA_PATH_WIDTH,
  localparam int PW             = PHASE_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sync,
  input  logic signed [W-1:0] Id,
  input  logic signed [W-1:0] Iq,
  output logic                angle_emulation,
  input  logic [PW-1:0]       phase_data,
  input  logic                phase_valid,
  output logic                phase_ready,
  output logic [PW-1:0]       angle_out_data,
  output logic                angle_out_valid,
  input  logic                angle_out_ready,
  input  logic signed [W-1:0] sin_in_data,
  input  logic [DW-1:0]       sin_in_dest,
  input  logic                sin_in_valid,
  output logic                sin_in_ready,
  input  logic signed [W-1:0] cos_in_data,
  input  logic [DW-1:0]       cos_in_dest,
  input  logic                cos_in_valid,
  output logic                cos_in_ready,
  output logic [W-1:0]        reference_out_data,
  output logic [DW-1:0]       reference_out_dest,
  output logic                reference_out_last,
  output logic                reference_out_valid,
  input  logic                reference_out_ready,
  input  logic [3:0]          axil_awaddr,
  input  logic                axil_awvalid,
  output logic                axil_awready,
  input  logic [31:0]         axil_wdata,
  input  logic [3:0]          axil_wstrb,
  input  logic                axil_wvalid,
  output logic                axil_wready,
  output logic [1:0]          axil_bresp,
  output logic                axil_bvalid,
  input  logic                axil_bready,
  input  logic [3:0]          axil_araddr,
  input  logic                axil_arvalid,
  output logic                axil_arready,
  output logic [31:0]         axil_rdata,
  output logic [1:0]          axil_rresp,
  output logic                axil_rvalid,
  input  logic                axil_rready
);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [DW-1:0]        LAST  = DW'(N_PHASES - 1);
  localparam logic signed [W+1:0]  S_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0]  S_MIN = {3'b111, {(W-1){1'b0}}};

  logic          emu_r, overrun_r, wr_sel_r;
  logic [PW-1:0] ph_adv_r, acc_r;
  logic [31:0]   per_r, per_cnt_r;
  logic          wr_en_s, clr_ovr_s, tc_s;
  logic signed [W-1:0]   id_r, iq_r;
  logic signed [2*W-1:0] p_d_r, p_q_r;
  logic                  v1_r;
  logic [DW-1:0]         dest1_r;
  logic signed [W+1:0]   sum_s;
  logic [W-1:0]          ref_s;
  logic [W-1:0]          bank_r [2][N_PHASES];
  state_t                state_r, state_n;
  logic [DW-1:0]         idx_r, idx_n;
  logic                  swap_s, overrun_set_s;
  logic                  unused;

  assign unused = ^{cos_in_dest, axil_wstrb, axil_awaddr[1:0], axil_araddr[1:0]};

  assign angle_emulation = emu_r;
  assign phase_ready     = emu_r ? 1'b1 : angle_out_ready;
  assign sin_in_ready    = 1'b1;
  assign cos_in_ready    = 1'b1;
  assign wr_en_s         = axil_awvalid && axil_wvalid && !axil_bvalid;
  assign axil_awready    = wr_en_s;
  assign axil_wready     = wr_en_s;
  assign axil_bresp      = 2'b00;
  assign axil_rresp      = 2'b00;
  assign axil_arready    = !axil_rvalid;
  assign clr_ovr_s       = wr_en_s && (axil_awaddr[3:2] == 2'd0) && axil_wdata[1];

  // Configuration writes and write response
  always_ff @(posedge clock) begin
    if (reset) begin
      emu_r       <= 1'b0;
      ph_adv_r    <= {PW{1'b0}};
      per_r       <= 32'd0;
      axil_bvalid <= 1'b0;
    end else if (wr_en_s) begin
      axil_bvalid <= 1'b1;
      case (axil_awaddr[3:2])
        2'd0:    emu_r    <= axil_wdata[0];
        2'd1:    ph_adv_r <= axil_wdata[PW-1:0];
        2'd2:    per_r    <= axil_wdata;
        default: ;
      endcase
    end else if (axil_bvalid && axil_bready) begin
      axil_bvalid <= 1'b0;
    end
  end

  // Register readback
  always_ff @(posedge clock) begin
    if (reset) begin
      axil_rvalid <= 1'b0;
      axil_rdata  <= 32'd0;
    end else if (axil_arvalid && !axil_rvalid) begin
      axil_rvalid <= 1'b1;
      case (axil_araddr[3:2])
        2'd0:    axil_rdata <= {31'd0, emu_r};
        2'd1:    axil_rdata <= 32'(ph_adv_r);
        2'd2:    axil_rdata <= per_r;
        default: axil_rdata <= {30'd0, (state_r == STREAM), overrun_r};
      endcase
    end else if (axil_rvalid && axil_rready) begin
      axil_rvalid <= 1'b0;
    end
  end

  // PER of 0 or 1 makes every cycle a terminal count
  assign tc_s = (per_r <= 32'd1) || (per_cnt_r >= per_r - 32'd1);

  // DDS period counter and phase accumulator
  always_ff @(posedge clock) begin
    if (reset) begin
      per_cnt_r <= 32'd0;
      acc_r     <= {PW{1'b0}};
    end else if (emu_r) begin
      if (tc_s) begin
        per_cnt_r <= 32'd0;
        acc_r     <= acc_r + ph_adv_r;
      end else begin
        per_cnt_r <= per_cnt_r + 32'd1;
      end
    end
  end

  // Angle output register and Id/Iq latch on angle handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      angle_out_valid <= 1'b0;
      angle_out_data  <= {PW{1'b0}};
      id_r            <= {W{1'b0}};
      iq_r            <= {W{1'b0}};
    end else begin
      if (angle_out_valid && angle_out_ready) begin
        id_r <= Id;
        iq_r <= Iq;
      end
      if (phase_valid && phase_ready) begin
        angle_out_valid <= 1'b1;
        angle_out_data  <= emu_r ? acc_r : phase_data;
      end else if (angle_out_valid && angle_out_ready) begin
        angle_out_valid <= 1'b0;
      end
    end
  end

  // Stage 1: products; out-of-range dest is discarded here
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_r    <= 1'b0;
      dest1_r <= {DW{1'b0}};
      p_d_r   <= {(2*W){1'b0}};
      p_q_r   <= {(2*W){1'b0}};
    end else begin
      v1_r    <= sin_in_valid && cos_in_valid && (32'(sin_in_dest) < N_PHASES);
      dest1_r <= sin_in_dest;
      p_d_r   <= (2*W)'(id_r) * (2*W)'(sin_in_data);
      p_q_r   <= -((2*W)'(iq_r) * (2*W)'(cos_in_data));
    end
  end

  // The extra guard bit keeps the full-scale corner sum from wrapping before it is reduced
  assign sum_s = (W+2)'(p_d_r >>> (W-1)) + (W+2)'(p_q_r >>> (W-1));

  // Reduce the stage-2 sum to W bits
  always_comb begin
    ref_s = sum_s[W-1:0];
`ifdef MPRS_SATURATION_EN
    if (sum_s > S_MAX) begin
      ref_s = {1'b0, {(W-1){1'b1}}};
    end else if (sum_s < S_MIN) begin
      ref_s = {1'b1, {(W-1){1'b0}}};
    end else begin
      ref_s = sum_s[W-1:0];
    end
`endif
  end

  // Stage 2: bank write; a write in the swap cycle still targets the outgoing bank
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_PHASES; i++) begin
          bank_r[b][i] <= {W{1'b0}};
        end
      end
    end else if (v1_r) begin
      bank_r[wr_sel_r][dest1_r] <= ref_s;
    end
  end

  // Output FSM state, beat index, bank select and sticky overrun
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= {DW{1'b0}};
      wr_sel_r  <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      if (swap_s) wr_sel_r <= !wr_sel_r;
      if (overrun_set_s) overrun_r <= 1'b1;
      else if (clr_ovr_s) overrun_r <= 1'b0;
    end
  end

  // Output FSM next state
  always_comb begin
    state_n       = state_r;
    idx_n         = idx_r;
    swap_s        = 1'b0;
    overrun_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sync) begin
          swap_s  = 1'b1;
          state_n = STREAM;
          idx_n   = {DW{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      STREAM: begin
        overrun_set_s = sync;
        if (reference_out_ready) begin
          if (idx_r == LAST) begin
            state_n = IDLE;
            idx_n   = {DW{1'b0}};
          end else begin
            idx_n = idx_r + DW'(1);
          end
        end else begin
          idx_n = idx_r;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = {DW{1'b0}};
      end
    endcase
  end

  assign reference_out_valid = (state_r == STREAM);
  assign reference_out_data  = reference_out_valid ? bank_r[!wr_sel_r][idx_r] : {W{1'b0}};
  assign reference_out_dest  = reference_out_valid ? idx_r : {DW{1'b0}};
  assign reference_out_last  = reference_out_valid && (idx_r == LAST);

endmodule
